sar_adc_ctrl: RTL and testbench
===============================

Name: sar_adc_ctrl

Overview:
Successive-approximation controller for the on-die analog front end (external DAC and comparator on the analog pins).
- Sequences track/hold, drives the trial DAC code MSB-first and reads the comparator each bit.
- Publishes the converted code on the dedicated outputs.
- Sits between the chip-level pin wrapper and the analog macro; one conversion per start request.

Parameters:
- NBITS, 8, resolution of the DAC code and result.
- SAMPLE_CYCLES, 4, cycles sample_o is held high (min 1).
- SETTLE_CYCLES, 2, DAC/comparator settle cycles per bit before decision (min 1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  design enable; low aborts and holds IDLE.
- start  input  1  conversion request; sampled only in IDLE.
- cmp_in  input  1  comparator output; 1 = Vin >= DAC voltage.
- sample_o  output  1  track/hold control; 1 = track.
- dac_code  output  NBITS  trial code to DAC.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the result updates.
- result  output  NBITS  last completed conversion.
- valid  output  1  a result has completed since reset.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- States: IDLE, SAMPLE, SETTLE, DECIDE, DONE.
- IDLE:
  - If ena && start at the edge, go to SAMPLE next cycle.
  - dac_code=0, sample_o=0, busy=0.
- SAMPLE:
  - sample_o=1 and dac_code=0 for exactly SAMPLE_CYCLES cycles.
  - Bit index is then set to NBITS-1.
  - Go to SETTLE with the trial bit set: dac_code[idx]=1.
- SETTLE:
  - Hold dac_code for SETTLE_CYCLES cycles, then go to DECIDE.
- DECIDE (1 cycle):
  - Register cmp_in. If 0, clear dac_code[idx]; if 1, keep it.
  - If idx>0: decrement idx, set the new trial bit, go to SETTLE.
  - If idx==0: go to DONE.
- DONE (1 cycle):
  - result<=final code, valid<=1, done=1.
  - Next state IDLE.
- Latency: done is high exactly 1+SAMPLE_CYCLES+NBITS*(SETTLE_CYCLES+1) cycles after the cycle start was accepted. Defaults give 29.
- start outside IDLE (including the DONE cycle) is ignored and not queued. The earliest back-to-back start is the cycle after done.
- ena low in any non-IDLE state:
  - Next state IDLE; no done pulse.
  - result and valid are unchanged; dac_code and sample_o go to 0.
- rst mid-conversion: all state and outputs return to reset values next cycle. valid clears.
- result is stable between done pulses; it never shows partial codes.
- cmp_in is ignored outside DECIDE.

Optional Feature:
- Macro: SAR_ADC_CMP_SYNC_EN.
- Defined:
  - cmp_in passes through a 2-flop synchronizer before DECIDE uses it.
  - Each bit's SETTLE time is extended to SETTLE_CYCLES+2 cycles.
  - Latency becomes 1+SAMPLE_CYCLES+NBITS*(SETTLE_CYCLES+3); defaults give 45.
- Undefined: cmp_in is used directly, with the latency above.
- The port list is identical in both builds.

Decomposition:
- Package sar_adc_pkg:
  - state enum (IDLE, SAMPLE, SETTLE, DECIDE, DONE);
  - localparam CMP_SYNC_STAGES=2;
  - width function for the cycle counter, clog2 of max(SAMPLE_CYCLES, SETTLE_CYCLES+CMP_SYNC_STAGES)+1.
- One sub-module, sar_cmp_sync:
  - 2-flop synchronizer, synchronous active-high reset to 0;
  - instantiated only under SAR_ADC_CMP_SYNC_EN.

Test Plan:
- Comparator model cmp_in=(vin>=dac_code), vin=0xA5, start pulse 1 cycle.
  -> sample_o high 4 cycles; done pulses 29 cycles after start; result=0xA5; valid=1; busy low the cycle after done.
- vin=0x00, then vin=0xFF, back-to-back (second start the cycle after done).
  -> results 0x00 then 0xFF; both latencies 29; dac_code trial sequence for 0xFF is 0x80, 0xC0, …, 0xFF.
- start held high continuously with vin=0x3C.
  -> one conversion every 30 cycles; done never on consecutive cycles; start during busy/DONE has no effect.
- ena dropped at cycle 10 of a conversion with prior result 0xA5.
  -> next cycle IDLE, no done, result stays 0xA5, dac_code=0, sample_o=0.
- rst asserted mid-SETTLE.
  -> next cycle all outputs 0 including valid and result; a subsequent start converts normally.
- Build with SAR_ADC_CMP_SYNC_EN, vin=0x5A.
  -> result 0x5A, done at 45 cycles after start.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg: shared states, constants and counter sizing for sar_adc_ctrl
package sar_adc_pkg;
  typedef enum logic [2:0] {IDLE, SAMPLE, SETTLE, DECIDE, DONE} state_e;
  localparam int CMP_SYNC_STAGES = 2;
  function automatic int cnt_w(input int sample_cycles, input int settle_cycles);
    int m;
    m = sample_cycles > settle_cycles + CMP_SYNC_STAGES ? sample_cycles : settle_cycles + CMP_SYNC_STAGES;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/sar_adc_ctrl_cmp_sync.sv
// sar_cmp_sync: two-flop synchronizer for the asynchronous comparator output
module sar_cmp_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], d};
  always_ff @(posedge clk) sync_q <= rst ? 2'b00 : sync_d;
  assign q = sync_q[1];
endmodule

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: SAR conversion sequencer (track/hold, MSB-first trial codes, result publish).
// Define SAR_ADC_CMP_SYNC_EN to synchronize cmp_in and stretch each settle by the sync depth.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int NBITS         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             cmp_in,
  output logic             sample_o,
  output logic [NBITS-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] result,
  output logic             valid
);
  localparam int CW = cnt_w(SAMPLE_CYCLES, SETTLE_CYCLES);
  localparam int IW = NBITS > 1 ? $clog2(NBITS) : 1;
  logic cmp_s;
`ifdef SAR_ADC_CMP_SYNC_EN
  localparam int SET_LEN = SETTLE_CYCLES + CMP_SYNC_STAGES;
  sar_cmp_sync u_sync (.clk(clk), .rst(rst), .d(cmp_in), .q(cmp_s));
`else
  localparam int SET_LEN = SETTLE_CYCLES;
  assign cmp_s = cmp_in;
`endif
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d, idx_n;
  logic [NBITS-1:0] dac_q, dac_d, result_q, result_d;
  logic             valid_q, valid_d;
  assign idx_n = idx_q - IW'(1);
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    idx_d    = idx_q;
    dac_d    = dac_q;
    result_d = result_q;
    valid_d  = valid_q;
    if (!ena) begin
      state_d = IDLE;
      dac_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          dac_d   = '0;
          state_d = start ? SAMPLE : IDLE;
        end
        SAMPLE: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(SAMPLE_CYCLES - 1)) begin
            cnt_d            = '0;
            idx_d            = IW'(NBITS - 1);
            dac_d[NBITS-1]   = 1'b1;
            state_d          = SETTLE;
          end
        end
        SETTLE: begin
          cnt_d   = cnt_q == CW'(SET_LEN - 1) ? '0 : cnt_q + CW'(1);
          state_d = cnt_q == CW'(SET_LEN - 1) ? DECIDE : SETTLE;
        end
        DECIDE: begin
          dac_d[idx_q] = cmp_s;
          if (idx_q != '0) begin
            idx_d        = idx_n;
            dac_d[idx_n] = 1'b1;
            state_d      = SETTLE;
          end else begin
            result_d = dac_d;
            valid_d  = 1'b1;
            state_d  = DONE;
          end
        end
        default: begin
          dac_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      dac_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dac_q    <= dac_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end
  assign sample_o = state_q == SAMPLE;
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign dac_code = dac_q;
  assign result   = result_q;
  assign valid    = valid_q;
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: directed scoreboard bench for sar_adc_ctrl with an ideal comparator model
module tb_sar_adc_ctrl;
`ifdef SAR_ADC_CMP_SYNC_EN
  localparam int LAT = 45;
  localparam int SP  = 5;
`else
  localparam int LAT = 29;
  localparam int SP  = 3;
`endif
  localparam int PER = LAT + 1;
  typedef struct {logic [7:0] code; int t;} exp_t;
  logic clk, rst, ena, start, cmp_in, sample_o, busy, done, valid;
  logic [7:0] dac_code, result, vin;
  exp_t sbq[$];
  int total, bad, cyc;
  logic prev_done;
  sar_adc_ctrl dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .cmp_in(cmp_in),
    .sample_o(sample_o), .dac_code(dac_code), .busy(busy), .done(done),
    .result(result), .valid(valid)
  );
  assign cmp_in = vin >= dac_code;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin
      chk("done_consecutive", {31'd0, prev_done}, 0);
      chk("sb_pending", {31'd0, sbq.size() != 0}, 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("latency", cyc - e.t, LAT);
        chk("result", {24'd0, result}, {24'd0, e.code});
        chk("valid_at_done", {31'd0, valid}, 1);
      end
    end
    prev_done = done;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic push(input logic [7:0] code, input int t);
    exp_t e;
    e.code = code;
    e.t    = t;
    sbq.push_back(e);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_valid"}, {31'd0, valid}, 0);
    chk({tag, "_result"}, {24'd0, result}, 0);
    chk({tag, "_dac"}, {24'd0, dac_code}, 0);
    chk({tag, "_sample"}, {31'd0, sample_o}, 0);
  endtask
  initial begin
    total = 0; bad = 0; cyc = 0; prev_done = 1'b0;
    rst = 1'b1; ena = 1'b1; start = 1'b0; vin = 8'h00;
    run(3);
    rst = 1'b0;
    chk_zero("reset");
    vin = 8'hA5;
    push(8'hA5, cyc);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("sample_first", {31'd0, sample_o}, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sample_hold", {31'd0, sample_o}, 1);
    end
    step();
    chk("sample_end", {31'd0, sample_o}, 0);
    run(LAT - 5);
    step();
    chk("busy_after_done", {31'd0, busy}, 0);
    chk("valid_after_done", {31'd0, valid}, 1);
    chk("result_hold", {24'd0, result}, 32'hA5);
    vin = 8'h3C;
    start = 1'b1;
    step();
    start = 1'b0;
    run(9);
    ena = 1'b0;
    step();
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_dac", {24'd0, dac_code}, 0);
    chk("abort_sample", {31'd0, sample_o}, 0);
    chk("abort_result", {24'd0, result}, 32'hA5);
    chk("abort_valid", {31'd0, valid}, 1);
    ena = 1'b1;
    run(LAT + 5);
    chk("abort_result_later", {24'd0, result}, 32'hA5);
    vin = 8'h00;
    push(8'h00, cyc);
    start = 1'b1;
    step();
    start = 1'b0;
    run(LAT - 1);
    vin = 8'hFF;
    step();
    push(8'hFF, cyc);
    start = 1'b1;
    step();
    start = 1'b0;
    run(4);
    for (int j = 0; j < 8; j++) begin
      chk("trial_ff", {24'd0, dac_code}, {24'd0, 8'(~(8'hFF >> (j + 1)))});
      run(SP);
    end
    step();
    vin = 8'h3C;
    for (int k = 0; k < 3; k++) push(8'h3C, cyc + k * PER);
    start = 1'b1;
    run(3 * PER);
    start = 1'b0;
    run(5);
    chk("cont_drained", sbq.size(), 0);
    chk("cont_idle", {31'd0, busy}, 0);
    vin = 8'h5A;
    start = 1'b1;
    step();
    start = 1'b0;
    run(5);
    rst = 1'b1;
    step();
    chk_zero("midrst");
    rst = 1'b0;
    push(8'h5A, cyc);
    start = 1'b1;
    step();
    start = 1'b0;
    run(LAT);
    chk("post_rst_valid", {31'd0, valid}, 1);
    chk("post_rst_result", {24'd0, result}, 32'h5A);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
